// File: rtl/fft_acc_pkg.sv
// fft_acc_pkg: shared constants, FSM state type and bit-reverse helper for
// the FFT accelerator sample-RAM reader.
//   ADDR_W  : word address width of the 32K-word sample RAM
//   DATA_W  : sample word width
//   state_e : reader FSM states
//   bit_rev : reverse the low n bits of an address-width value
package fft_acc_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Reverse all ADDR_W bits, then shift down so only the low n bits of v
    // land (reversed) in the low n bits of the result. Bits of v at or above
    // n fall off the bottom.
    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v,
                                                  input logic [3:0]        n);
        logic [ADDR_W-1:0] full;
        for (int i = 0; i < ADDR_W; i++) full[i] = v[ADDR_W-1-i];
        return full >> (ADDR_W - int'(n));
    endfunction

endpackage

// File: rtl/fft_acc_sfifo.sv
// fft_acc_sfifo: small synchronous FIFO with registered storage and pointers.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, data_i : write side (caller guarantees no push when full)
//   pop_i          : read side (caller guarantees no pop when empty)
//   data_o         : head word, forced to 0 while empty
//   valid_o        : FIFO non-empty
//   count_o        : current occupancy, 0..DEPTH
module fft_acc_sfifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/fft_acc_ram_reader.sv
// fft_acc_ram_reader: Avalon-MM read master on port s2 of the FFT sample RAM.
// Reads a block of words in linear or bit-reversed order and streams them out.
//   clk, reset            : clock, asynchronous active-high reset
//   start, base_addr,
//   length, bitrev, log2n : block command (sampled in IDLE only)
//   busy, done            : block in progress / one-cycle completion pulse
//   address, chipselect,
//   write, byteenable     : Avalon read master (1-cycle read latency)
//   readdata              : RAM data, valid the cycle after chipselect
//   out_data, out_valid,
//   out_ready, out_last   : valid/ready output stream
module fft_acc_ram_reader #(
    parameter int ADDR_W     = fft_acc_pkg::ADDR_W,
    parameter int DATA_W     = fft_acc_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       length,
    input  logic              bitrev,
    input  logic [3:0]        log2n,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [3:0]        byteenable,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    import fft_acc_pkg::*;

    localparam int                CW      = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0]     DEPTH_V = (CW+2)'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       len_q, len_d, idx_q, idx_d;
    logic              bitrev_q, bitrev_d;
    logic [3:0]        log2n_q, log2n_d;
    logic              infl_q, last_q, last_d, done_q, done_d;

    logic              issue, is_final, pop;
    logic [CW:0]       fifo_cnt;
    logic [DATA_W:0]   fifo_dout;
    logic              fifo_valid;
    logic [ADDR_W-1:0] offset;

    assign is_final = (idx_q == len_q - 16'd1);

    // Credit check: words already buffered plus the read on the bus must
    // leave room, so the FIFO can never overflow even with no pops.
    assign issue = (state_q == RUN) &&
                   (({1'b0, fifo_cnt} + {{(CW+1){1'b0}}, infl_q}) < DEPTH_V);

    assign offset  = bitrev_q ? bit_rev(idx_q[ADDR_W-1:0], log2n_q)
                              : idx_q[ADDR_W-1:0];
    assign address = base_q + offset;   // wraps modulo 2^ADDR_W

    assign pop = fifo_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        bitrev_d = bitrev_q;
        log2n_d  = log2n_q;
        done_d   = 1'b0;
        last_d   = issue & is_final;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 16'd0) begin
                        base_d   = base_addr;
                        len_d    = length;
                        bitrev_d = bitrev;
                        log2n_d  = log2n;
                        idx_d    = '0;
                        state_d  = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    idx_d = idx_q + 16'd1;
                    if (is_final) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The head word's stored last flag marks the block end.
                if (pop && fifo_dout[DATA_W]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            bitrev_q <= 1'b0;
            log2n_q  <= '0;
            infl_q   <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            bitrev_q <= bitrev_d;
            log2n_q  <= log2n_d;
            infl_q   <= issue;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    fft_acc_sfifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (infl_q),
        .data_i  ({last_q, readdata}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign chipselect = issue;
    assign write      = 1'b0;
    assign byteenable = 4'hF;
    assign out_data   = fifo_dout[DATA_W-1:0];
    assign out_last   = fifo_dout[DATA_W];
    assign out_valid  = fifo_valid;

endmodule

// File: doc/fft_acc_ram_reader.md
# fft_acc_ram_reader

Avalon-MM read master for the second port (s2) of the FFT accelerator's 32K x 32 dual-port sample RAM. On a start command it reads a contiguous block of words, in linear or bit-reversed order, and presents them on a valid/ready stream to the FFT datapath. It absorbs the RAM's fixed one-cycle read latency and stream back-pressure with a small credit-controlled FIFO.

## Interface
- ADDR_W, 15, word address width of the RAM port.
- DATA_W, 32, data width.
- FIFO_DEPTH, 4, output buffer depth in words; power of two, at least 2.
- clk  in  1  single clock for the block and the RAM port it drives.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address of the block.
- length  in  16  word count, 0..32768.
- bitrev  in  1  1 = bit-reversed read order over log2n bits.
- log2n  in  4  transform size exponent, 1..15; used only when bitrev=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the block is fully delivered.
- address  out  ADDR_W  Avalon read address.
- chipselect  out  1  read strobe; one word is read per asserted cycle.
- write  out  1  constant 0.
- byteenable  out  4  constant 4'hF.
- readdata  in  DATA_W  RAM data, valid exactly one cycle after chipselect.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of the block.

## Operation
- States:
  - IDLE: start with length≠0 latches base_addr, length, bitrev and log2n, clears index, then goes to RUN. start with length=0 pulses done next cycle and stays in IDLE.
  - RUN: issues reads. When the last index is issued, goes to DRAIN.
  - DRAIN: waits until the final word is accepted (out_valid & out_ready & out_last), then pulses done and returns to IDLE.
- Read address:
  - bitrev=0: base_addr + index.
  - bitrev=1: base_addr + rev(index[log2n-1:0]), where rev reverses only the low log2n bits.
  - The sum wraps modulo 2^ADDR_W.
- With bitrev=1, length must equal 2^log2n. Other lengths are out of contract, but the block must still terminate after exactly length words.
- Read issue rule: a read is issued only when FIFO occupancy + in-flight reads < FIFO_DEPTH. There is at most one read in flight.
- Each readdata word is pushed into the FIFO in the cycle it arrives. Its out_last flag is the registered "issued index == length-1" bit.
- start while busy is ignored. Parameters are never re-latched mid-block.
- Output order equals issue order. No word is dropped or duplicated under any out_ready pattern.

## Timing
- Reset values: busy=0, done=0, chipselect=0, address=0, out_valid=0, out_data=0, out_last=0, FSM in IDLE, FIFO empty.
- Pipeline from start at cycle 0:
  - cycle 1: first chipselect.
  - cycle 2: readdata captured.
  - cycle 3: out_valid=1.
- Latency: 3 cycles start→first word.
- Throughput: with out_ready held high, 1 word/cycle and no bubbles.
- done is asserted the cycle after the last handshake. busy falls in that same cycle.
- FIFO full: chipselect stays deasserted; no read is issued that could overflow the FIFO.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- Reset mid-block:
  - Everything returns to its reset value immediately.
  - In-flight readdata is discarded.
  - No done pulse is generated.

## Structure
- The fft_acc_pkg package holds:
  - ADDR_W and DATA_W constants.
  - The state enum {IDLE, RUN, DRAIN}.
  - A bit-reverse function parameterised by log2n.
- One sub-module, fft_acc_sfifo:
  - Synchronous FIFO of width DATA_W+1, holding data plus the last flag.
  - Registered outputs.
  - Exposes a count output, used for credit accounting.

## Test plan
- Linear read: base=0x0010, length=8, RAM[i]=i, out_ready=1 → words 0x10..0x17, one per cycle starting at cycle 3; out_last on 0x17; done one cycle later.
- Bit-reverse read: base=0, log2n=3, length=8 → data order 0,4,2,6,1,5,3,7.
- Address wrap: base=0x7FFE, length=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Back-pressure: out_ready random at 30% for length=64 → all 64 words in order; chipselect never asserted when count+inflight=4.
- length=0 start → done pulse at cycle 1; chipselect never asserted; busy stays 0.
- Abort and restart: assert reset at word 5 of 16 → all outputs 0 next cycle; a following start produces a clean block with no stale word.
